// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: shared FSM state type and default parameter values
// for the clock_monitor block and its synchronizer sub-module.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } mon_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_EXP_PERIOD  = 12;
  localparam int DEF_TOL         = 1;
  localparam int DEF_LOCK_COUNT  = 4;
  localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings the asynchronous clk_mon into the clk_in domain
// through a SYNC_STAGES-deep flop chain and emits a registered one-cycle
// pulse on every 0->1 transition of the last stage. The pulse appears a
// fixed SYNC_STAGES+1 clk_in cycles after clk_mon is first sampled high.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clk_mon,
  output logic rise
);

  // Fewer than two stages would not give metastability protection.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Shift clk_mon through the chain and register the rising-edge pulse
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], clk_mon};
      last_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: measures the period of clk_mon in clk_in cycles, declares
// lock after LOCK_COUNT consecutive in-tolerance periods and declares loss
// after TIMEOUT cycles without a clk_mon rising edge.
// Optional feature macro: CLOCK_MONITOR_STICKY_ERR_EN adds err_clr/err_sticky,
// a sticky flag for any out-of-tolerance period or entry to LOST.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_mon,
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             clk_lost
);

  localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  // Comparisons run in a width wide enough for both cnt and any int bound,
  // so nothing wraps when cnt is below EXP_PERIOD or TOL exceeds EXP_PERIOD.
  localparam int EXT_W  = CNT_W + 32;
  localparam int TOL_LO = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam int TOL_HI = EXP_PERIOD + TOL;

  mon_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              rise;
  logic [EXT_W-1:0]  cnt_ext;
  logic              in_tol;
  logic              at_timeout;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_in  (clk_in),
    .rst     (rst),
    .clk_mon (clk_mon),
    .rise    (rise)
  );

  // Judge the running count against the tolerance window and the timeout
  always_comb begin
    cnt_ext    = EXT_W'(cnt);
    in_tol     = (cnt_ext >= EXT_W'(TOL_LO)) && (cnt_ext <= EXT_W'(TOL_HI));
    at_timeout = (cnt_ext == EXT_W'(TIMEOUT));
  end

  // Period counter and lock/loss FSM; an edge always takes priority over a timeout
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      clk_lost     <= 1'b0;
    end else begin
      period_valid <= 1'b0;

      if (rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
          end else if (at_timeout) begin
            state    <= LOST;
            clk_lost <= 1'b1;
          end
        end

        MEASURE: begin
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (in_tol) begin
              good_cnt <= good_cnt + GOOD_W'(1);
              if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (at_timeout) begin
            state    <= LOST;
            clk_lost <= 1'b1;
            good_cnt <= '0;
          end
        end

        LOCKED: begin
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (!in_tol) begin
              state    <= MEASURE;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
          end else if (at_timeout) begin
            state    <= LOST;
            locked   <= 1'b0;
            clk_lost <= 1'b1;
            good_cnt <= '0;
          end
        end

        LOST: begin
          if (rise) begin
            state    <= MEASURE;
            clk_lost <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CLOCK_MONITOR_STICKY_ERR_EN
  logic err_set;

  // An error is a measured period outside the window or any entry to LOST
  always_comb begin
    err_set = 1'b0;
    if (rise && (state == MEASURE || state == LOCKED) && !in_tol) begin
      err_set = 1'b1;
    end
    if (!rise && at_timeout && state != LOST) begin
      err_set = 1'b1;
    end
  end

  // Hold the error flag until cleared; a new error beats a simultaneous clear
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (err_set) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: drives clk_mon as a sequence of whole periods (directed
// and $urandom) aligned to clk_in and compares every cycle against a
// timestamp-based reference model of the monitor's observable behaviour.
// Define CLOCK_MONITOR_STICKY_ERR_EN to also exercise err_clr/err_sticky.
`timescale 1ns/1ps
module tb_clock_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;
  localparam int EXP_PERIOD  = 12;
  localparam int TOL         = 1;
  localparam int LOCK_COUNT  = 4;
  localparam int TIMEOUT     = 64;
  // clk_mon driven before posedge c+1 is detected SYNC_STAGES+1 cycles later,
  // and the resulting outputs register one cycle after that.
  localparam int LAT         = SYNC_STAGES + 2;

  logic             clk_in;
  logic             rst;
  logic             clk_mon;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             clk_lost;
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
  logic             err_clr;
  logic             err_sticky;
`endif

  clock_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .EXP_PERIOD  (EXP_PERIOD),
    .TOL         (TOL),
    .LOCK_COUNT  (LOCK_COUNT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .clk_mon      (clk_mon),
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
    .err_clr      (err_clr),
    .err_sticky   (err_sticky),
`endif
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .clk_lost     (clk_lost)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: edge timestamps, not counters.
  int cyc;
  int det_q[$];
  int armed;
  int last_det;
  int ref_cyc;
  int good;
  int m_period;
  int m_pv;
  int m_locked;
  int m_lost;
  int m_sticky;
  int clr_at;
  logic mon_drv;

  task automatic check_output(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    det_q.delete();
    armed    = 0;
    last_det = 0;
    ref_cyc  = cyc + 1;
    good     = 0;
    m_period = 0;
    m_pv     = 0;
    m_locked = 0;
    m_lost   = 0;
    m_sticky = 0;
    clr_at   = -1;
  endtask

  task automatic model_step();
    int p;
    int err_set;
    err_set = 0;
    m_pv    = 0;
    if (det_q.size() > 0 && det_q[0] == cyc) begin
      void'(det_q.pop_front());
      if (armed != 0) begin
        p        = cyc - last_det;
        m_period = p;
        m_pv     = 1;
        if (p >= EXP_PERIOD - TOL && p <= EXP_PERIOD + TOL) good++;
        else begin
          good    = 0;
          err_set = 1;
        end
        m_locked = (good >= LOCK_COUNT) ? 1 : 0;
      end else begin
        armed  = 1;
        m_lost = 0;
      end
      last_det = cyc;
      ref_cyc  = cyc;
    end else if (m_lost == 0 && (cyc - ref_cyc) == TIMEOUT) begin
      m_lost   = 1;
      m_locked = 0;
      armed    = 0;
      good     = 0;
      err_set  = 1;
    end
    if (err_set != 0) m_sticky = 1;
    else if (clr_at == cyc) m_sticky = 0;
  endtask

  // One clk_in cycle: check the outputs of the posedge just gone, then drive the next inputs.
  task automatic apply_stimulus(input logic mon, input logic clr);
    @(negedge clk_in);
    cyc++;
    model_step();
    check_output("period_valid", int'(period_valid), m_pv);
    check_output("locked", int'(locked), m_locked);
    check_output("clk_lost", int'(clk_lost), m_lost);
    check_output("period", int'(period), m_period);
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
    check_output("err_sticky", int'(err_sticky), m_sticky);
    err_clr = clr;
`endif
    if (clr) clr_at = cyc + 1;
    if (mon && !mon_drv) det_q.push_back(cyc + LAT);
    mon_drv = mon;
    clk_mon = mon;
  endtask

  task automatic run_period(input int p, input int clr_tick);
    for (int i = 0; i < p; i++) begin
      apply_stimulus((i < p / 2) ? 1'b1 : 1'b0, (i == clr_tick) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string phase);
    check_output({phase, "_period"}, int'(period), 0);
    check_output({phase, "_period_valid"}, int'(period_valid), 0);
    check_output({phase, "_locked"}, int'(locked), 0);
    check_output({phase, "_clk_lost"}, int'(clk_lost), 0);
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
    check_output({phase, "_err_sticky"}, int'(err_sticky), 0);
`endif
  endtask

  // Assert reset between clock edges, check outputs clear at once, release on a negedge.
  task automatic async_reset();
    #2;
    rst     = 1'b1;
    clk_mon = 1'b0;
    mon_drv = 1'b0;
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk_in);
    cyc++;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst     = 1'b1;
    clk_mon = 1'b0;
    mon_drv = 1'b0;
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    cyc = 0;
    #1;
    check_reset_outputs("reset");
    repeat (2) begin
      @(negedge clk_in);
      cyc++;
    end
    rst = 1'b0;
    model_reset();

    $display("[TB] nominal divide-by-12 lock");
    hold_low(3);
    repeat (6) run_period(12, -1);

    $display("[TB] tolerance boundaries 11/13 then 10/14");
    run_period(11, -1);
    run_period(13, -1);
    repeat (6) run_period($urandom_range(EXP_PERIOD + TOL, EXP_PERIOD - TOL), -1);
    run_period(10, -1);
    run_period(12, -1);
    run_period(14, -1);
    repeat (5) run_period(12, -1);

    $display("[TB] single stretched period while locked");
    run_period(16, -1);
    run_period(12, 3);
    repeat (4) run_period(12, -1);
    run_period(12, 5);
    repeat (2) run_period(12, -1);

    $display("[TB] random periods");
    repeat (16) run_period($urandom_range(15, 9), -1);
    repeat (6) run_period(12, -1);

    $display("[TB] clock loss and restart");
    hold_low(80);
    repeat (6) run_period(12, -1);

    $display("[TB] edge coinciding with timeout, then one cycle late");
    run_period(64, -1);
    run_period(65, -1);
    repeat (6) run_period(12, 2);

    $display("[TB] reset mid-period while locked");
    repeat (6) apply_stimulus(1'b1, 1'b0);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    async_reset();
    hold_low(3);
    repeat (6) run_period(12, -1);
    hold_low(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
